// File: rtl/bist_ctrl_param_if.sv
// Control and status bundle between a scan-BIST sequencer and the
// harness that launches sessions and supplies the MISR signature.
interface bist_ctrl_param_if #(
    parameter int SIG_W = 16,
    parameter int PAT_W = 4
);
    logic             START;
    logic             ABORT;
    logic [SIG_W-1:0] MISR_SIG;
    logic             INIT;
    logic             RUNNING;
    logic             SCAN_EN;
    logic             SEED_SEL;
    logic             FINISH;
    logic             BIST_END;
    logic             PASS;
    logic             ABORTED;
    logic [PAT_W-1:0] PAT_IDX;

    modport master (
        output START, ABORT, MISR_SIG,
        input  INIT, RUNNING, SCAN_EN, SEED_SEL, FINISH,
        input  BIST_END, PASS, ABORTED, PAT_IDX
    );

    modport slave (
        input  START, ABORT, MISR_SIG,
        output INIT, RUNNING, SCAN_EN, SEED_SEL, FINISH,
        output BIST_END, PASS, ABORTED, PAT_IDX
    );
endinterface

// File: rtl/bist_ctrl_param.sv
// Scan-BIST sequencer: NUM_PAT patterns of SCAN_LEN shifts plus one
// capture, LFSR seed switch, golden MISR compare, abort and re-arm.
module bist_ctrl_param #(
    parameter int              SCAN_LEN    = 9,
    parameter int              NUM_PAT     = 9,
    parameter int              SEED_SWITCH = 6,
    parameter int              SIG_W       = 16,
    parameter logic [SIG_W-1:0] GOLDEN     = '0
) (
    input logic              CLK,
    input logic              RESET,
    bist_ctrl_param_if.slave bus
);
    localparam int BW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam int PW = $clog2(NUM_PAT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SCAN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PAT - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ARM   = 4'd1,
        S_INIT  = 4'd2,
        S_SHIFT = 4'd3,
        S_CAP   = 4'd4,
        S_FIN   = 4'd5,
        S_HOLD  = 4'd6,
        S_DONE  = 4'd7
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [PW-1:0] pat_q, pat_d;
    logic          pass_q, pass_d;
    logic          abrt_q, abrt_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            pat_q   <= '0;
            pass_q  <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            pat_q   <= pat_d;
            pass_q  <= pass_d;
            abrt_q  <= abrt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        pat_d   = pat_q;
        pass_d  = pass_q;
        abrt_d  = abrt_q;
        case (state_q)
            S_IDLE: if (!bus.START) state_d = S_ARM;
            S_ARM, S_DONE: begin
                // session flags are cleared on entry so INIT already shows them low
                if (bus.START) begin
                    state_d = S_INIT;
                    bit_d   = '0;
                    pat_d   = '0;
                    pass_d  = 1'b0;
                    abrt_d  = 1'b0;
                end
            end
            S_INIT: begin
                bit_d = '0;
                pat_d = '0;
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                    abrt_d  = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                    pass_d  = 1'b0;
                    abrt_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                    abrt_d  = 1'b1;
                    bit_d   = '0;
                    pat_d   = '0;
                end else if (bit_q == BIT_LAST) begin
                    state_d = S_CAP;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            S_CAP: begin
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                    abrt_d  = 1'b1;
                    bit_d   = '0;
                    pat_d   = '0;
                end else if (pat_q == PAT_LAST) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_SHIFT;
                    pat_d   = pat_q + 1'b1;
                end
            end
            S_FIN: begin
                pass_d  = (bus.MISR_SIG == GOLDEN);
                state_d = S_HOLD;
            end
            S_HOLD: if (!bus.START) state_d = S_DONE;
            default: begin
                state_d = S_IDLE;
                bit_d   = '0;
                pat_d   = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.INIT     = 1'b0;
        bus.RUNNING  = 1'b0;
        bus.SCAN_EN  = 1'b0;
        bus.SEED_SEL = 1'b0;
        bus.FINISH   = 1'b0;
        bus.BIST_END = 1'b0;
        bus.PASS     = 1'b0;
        bus.ABORTED  = 1'b0;
        bus.PAT_IDX  = '0;
        case (state_q)
            S_IDLE, S_ARM: begin
                bus.ABORTED = abrt_q;
                bus.PAT_IDX = pat_q;
            end
            S_INIT: begin
                bus.INIT    = 1'b1;
                bus.ABORTED = abrt_q;
                bus.PAT_IDX = pat_q;
            end
            S_SHIFT, S_CAP: begin
                bus.RUNNING  = 1'b1;
                bus.SCAN_EN  = (state_q == S_SHIFT);
                bus.SEED_SEL = (int'(pat_q) >= SEED_SWITCH);
                bus.ABORTED  = abrt_q;
                bus.PAT_IDX  = pat_q;
            end
            S_FIN, S_HOLD, S_DONE: begin
                bus.FINISH   = (state_q == S_FIN);
                bus.BIST_END = 1'b1;
                bus.PASS     = pass_q;
                bus.ABORTED  = abrt_q;
                bus.PAT_IDX  = pat_q;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/bist_ctrl_param.md
Name: bist_ctrl_param

Overview:
- Parametrised next-generation scan-BIST sequencer, placed between the pattern generator (LFSR with two seeds), the scan chain under test and the response compactor (MISR).
- Runs NUM_PAT patterns, each SCAN_LEN shift cycles plus one capture cycle, and switches the LFSR seed at a programmable pattern index.
- At end of test it compares the MISR signature to a golden value and reports PASS.
- Supports abort and re-arm on a fresh START rising edge.

Parameters:
- SCAN_LEN, 9: shift cycles per pattern, ≥1.
- NUM_PAT, 9: patterns per session, ≥1.
- SEED_SWITCH, 6: first pattern index driven with SEED_SEL=1. A value ≥ NUM_PAT means never.
- SIG_W, 16: MISR signature width.
- GOLDEN, 16'h0000: expected signature, SIG_W bits.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  session request, level; a session starts on a sampled 0→1 sequence.
- ABORT  in  1  synchronous abort of a running session.
- MISR_SIG  in  SIG_W  compactor signature, stable during the FINISH cycle.
- INIT  out  1  one-cycle pulse; loads the LFSR seed and clears the MISR.
- RUNNING  out  1  high for every shift and capture cycle.
- SCAN_EN  out  1  1 = shift, 0 = capture/functional.
- SEED_SEL  out  1  selects the alternate LFSR seed.
- FINISH  out  1  one-cycle end-of-test pulse.
- BIST_END  out  1  session complete, held.
- PASS  out  1  registered compare result, valid while BIST_END=1.
- ABORTED  out  1  sticky; last session was aborted.
- PAT_IDX  out  clog2(NUM_PAT+1)  current pattern index.

Behaviour:
- Reset: state=IDLE; bit_cnt=0, pat_cnt=0; PASS=0, ABORTED=0. All outputs 0.
- Outputs are Moore outputs, decoded from registered state, counters and flags only. There is no combinational path from inputs to outputs.
- IDLE: wait for START=0, then go to ARM. A START held high out of reset never launches a session.
- ARM: on START=1 go to INIT.
- INIT (1 cycle): INIT=1. Clear bit_cnt, pat_cnt, PASS and ABORTED. Next state SHIFT.
- SHIFT:
  - RUNNING=1, SCAN_EN=1. bit_cnt increments each cycle.
  - When bit_cnt==SCAN_LEN-1, clear bit_cnt and go to CAPTURE.
- CAPTURE (1 cycle): RUNNING=1, SCAN_EN=0.
  - If pat_cnt==NUM_PAT-1, go to FINISH.
  - Otherwise pat_cnt+1 and go to SHIFT.
- SEED_SEL = RUNNING and (pat_cnt ≥ SEED_SWITCH). It is 0 in every other state.
- PAT_IDX = pat_cnt.
- FINISH (1 cycle): FINISH=1, BIST_END=1, RUNNING=0. Register PASS = (MISR_SIG==GOLDEN). Next state HOLD.
- HOLD: BIST_END=1, PASS held. On START=0 go to DONE.
- DONE: BIST_END=1, PASS held. On START=1 go to INIT, which clears BIST_END and PASS.
- Session length: INIT on the cycle after START is sampled high in ARM.
  - RUNNING lasts NUM_PAT*(SCAN_LEN+1) cycles, which is 90 at defaults.
  - FINISH follows immediately.
- ABORT:
  - Sampled 1 in INIT, SHIFT or CAPTURE: set ABORTED=1, clear the counters, go to IDLE. All run outputs drop the next cycle; FINISH and BIST_END are not asserted.
  - Ignored in IDLE, ARM, FINISH, HOLD and DONE.
  - ABORT has priority over every other transition in the same cycle.
- START toggling during INIT, SHIFT or CAPTURE is ignored.
- Counter widths are sized with clog2 of SCAN_LEN and NUM_PAT+1. Counters never wrap within a session.
- Degenerate case SCAN_LEN=1: SHIFT lasts exactly 1 cycle per pattern.
- Illegal state encodings recover to IDLE with all outputs 0.
- RESET asserted mid-session: immediate return to the reset values, ABORTED=0, and START must be seen low again before a new session.

Test Plan:
- Defaults, RESET released with START=0, then START pulsed high → INIT one cycle later; RUNNING high 90 cycles; SCAN_EN low exactly on run cycles 9, 19, …, 89 (0-based); FINISH one cycle; BIST_END held.
- SEED_SEL check, defaults → SEED_SEL=0 for pat 0–5 and 1 for pat 6–8; 0 outside RUNNING; PAT_IDX 0..8 observed.
- MISR_SIG=GOLDEN in the FINISH cycle → PASS=1 held through HOLD/DONE. Rerun with MISR_SIG=GOLDEN^1 → PASS=0. A new START clears PASS at INIT.
- START held 1 across BIST_END → stays in HOLD. Drop START, then raise it → second full 90-cycle session, BIST_END low from INIT.
- ABORT=1 at run cycle 40 → RUNNING/SCAN_EN low next cycle; ABORTED=1; no FINISH. A new session needs START 0→1; ABORTED clears at INIT.
- SCAN_LEN=1, NUM_PAT=3, SEED_SWITCH=5 → RUNNING 6 cycles with SCAN_EN 1,0,1,0,1,0; SEED_SEL never 1.
- RESET pulsed mid-shift → all outputs 0 immediately; START held high after reset → no session until START goes low then high.
